// File: rtl/ro_puf_pkg.sv
// Shared constants for the ring-oscillator PUF measurement controller.
package ro_puf_pkg;

  localparam int DEF_CNT_W  = 12;
  localparam int DEF_WINDOW = 1024;
  localparam int HOLD_CYC   = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_COUNT  = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;
  localparam state_t ST_CMP    = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_puf_meas_ctrl_if.sv
// Bundle between the measurement controller, the RO counter pair and the response consumer.
interface ro_puf_meas_ctrl_if #(
  parameter int CNT_W     = 12,
  parameter int RESP_BITS = 8
);
  localparam int PAIR_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  logic                 start;
  logic                 abort;
  logic [CNT_W-1:0]     cnt_a;
  logic [CNT_W-1:0]     cnt_b;
  logic                 cnt_en;
  logic                 cnt_clr;
  logic [PAIR_W-1:0]    pair_sel;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] resp;
  logic [RESP_BITS-1:0] tie;

  modport master (
    input  start, abort, cnt_a, cnt_b,
    output cnt_en, cnt_clr, pair_sel, busy, done, resp, tie
  );

  modport slave (
    output start, abort, cnt_a, cnt_b,
    input  cnt_en, cnt_clr, pair_sel, busy, done, resp, tie
  );

endinterface

// File: rtl/ro_puf_window_timer.sv
// Down-counter shared by SETTLE/COUNT/HOLD; loaded with dwell-1, expires when it reaches zero.
module ro_puf_window_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire
);

  logic [W-1:0] r_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (r_value != '0) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_expire = (r_value == '0);

endmodule

// File: rtl/ro_puf_meas_ctrl.sv
// Sequences clear/settle/count/hold/compare per RO pair and shifts the comparison
// results into a RESP_BITS-wide PUF response published with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | counters held clear, waiting for start
// CLEAR  | one cycle of counter clear for the selected pair
// SETTLE | RO mux settling, counters released but disabled
// COUNT  | counters enabled for exactly WINDOW cycles
// HOLD   | counters frozen while their outputs settle
// CMP    | compare cnt_a/cnt_b, record resp/tie bit for pair_sel
// DONE   | publish response, one-cycle done pulse
module ro_puf_meas_ctrl
  import ro_puf_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int SETTLE_CYC = 4,
  parameter int RESP_BITS  = 8
) (
  input logic               clk,
  input logic               reset,
  ro_puf_meas_ctrl_if.master bus
);

  localparam int PAIR_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TMR_W  = $clog2(max2(WINDOW, SETTLE_CYC) + 1);
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(RESP_BITS - 1);

  state_t               r_state, w_next;
  logic [PAIR_W-1:0]    r_pair;
  logic [RESP_BITS-1:0] r_resp_wrk, r_tie_wrk, w_resp_wrk, w_tie_wrk;
  logic [RESP_BITS-1:0] r_resp, r_tie;
  logic                 r_cnt_en, r_cnt_clr, r_busy, r_done;
  logic                 w_tmr_load, w_tmr_expire;
  logic [TMR_W-1:0]     w_tmr_val;
  logic [CNT_W-1:0]     w_a, w_b;

  assign w_a = bus.cnt_a;
  assign w_b = bus.cnt_b;

  always_comb begin
    w_next = r_state;
    if (r_state != ST_IDLE && bus.abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (bus.start && !bus.abort) w_next = ST_CLEAR;
        ST_CLEAR:  w_next = ST_SETTLE;
        ST_SETTLE: if (w_tmr_expire) w_next = ST_COUNT;
        ST_COUNT:  if (w_tmr_expire) w_next = ST_HOLD;
        ST_HOLD:   if (w_tmr_expire) w_next = ST_CMP;
        ST_CMP:    w_next = (r_pair == LAST_PAIR) ? ST_DONE : ST_CLEAR;
        ST_DONE:   w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Timer is reloaded on every state change; only SETTLE/COUNT/HOLD consult it.
  always_comb begin
    w_tmr_load = (w_next != r_state);
    case (w_next)
      ST_SETTLE: w_tmr_val = TMR_W'(SETTLE_CYC - 1);
      ST_COUNT:  w_tmr_val = TMR_W'(WINDOW - 1);
      ST_HOLD:   w_tmr_val = TMR_W'(HOLD_CYC - 1);
      default:   w_tmr_val = '0;
    endcase
  end

  ro_puf_window_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_tmr_expire)
  );

  always_comb begin
    w_resp_wrk = r_resp_wrk;
    w_tie_wrk  = r_tie_wrk;
    if (r_state == ST_CMP) begin
      w_resp_wrk[r_pair] = (w_a > w_b);
      w_tie_wrk[r_pair]  = (w_a == w_b);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pair     <= '0;
      r_resp_wrk <= '0;
      r_tie_wrk  <= '0;
      r_resp     <= '0;
      r_tie      <= '0;
      r_cnt_en   <= 1'b0;
      r_cnt_clr  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt_en   <= (w_next == ST_COUNT);
      r_cnt_clr  <= (w_next == ST_IDLE) || (w_next == ST_CLEAR);
      r_busy     <= (w_next != ST_IDLE);
      r_done     <= (w_next == ST_DONE);
      r_resp_wrk <= w_resp_wrk;
      r_tie_wrk  <= w_tie_wrk;
      if (r_state == ST_IDLE && w_next == ST_CLEAR) begin
        r_pair     <= '0;
        r_resp_wrk <= '0;
        r_tie_wrk  <= '0;
      end else if (r_state == ST_CMP && w_next == ST_CLEAR) begin
        r_pair <= r_pair + 1'b1;
      end else if (w_next == ST_DONE) begin
        r_pair <= '0;
        r_resp <= w_resp_wrk;
        r_tie  <= w_tie_wrk;
      end
    end
  end

  assign bus.cnt_en   = r_cnt_en;
  assign bus.cnt_clr  = r_cnt_clr;
  assign bus.pair_sel = r_pair;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.resp     = r_resp;
  assign bus.tie      = r_tie;

endmodule

// File: tb/tb_ro_puf_meas_ctrl.sv
// Self-checking bench: table-driven runs with a done scoreboard plus abort/reset/busy-start sequences.
module tb_ro_puf_meas_ctrl;

  localparam int WIN   = 16;
  localparam int SET   = 2;
  localparam int RB    = 4;
  localparam int CW    = 12;
  localparam int LAT   = 89;
  localparam int NV    = 4;

  typedef struct {
    logic [RB-1:0][CW-1:0] a;
    logic [RB-1:0][CW-1:0] b;
    logic [RB-1:0]         resp;
    logic [RB-1:0]         tie;
  } vec_t;

  typedef struct {
    logic [RB-1:0] resp;
    logic [RB-1:0] tie;
    int unsigned   t0;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  ro_puf_meas_ctrl_if #(.CNT_W(CW), .RESP_BITS(RB)) bus ();

  ro_puf_meas_ctrl #(
    .CNT_W      (CW),
    .WINDOW     (WIN),
    .SETTLE_CYC (SET),
    .RESP_BITS  (RB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned n_edge = 0;
  int unsigned n_done = 0;
  int          en_cyc;
  int          en_run = 0;
  bit          en_chk = 1'b1;
  exp_t        sb[$];
  vec_t        vecs[NV];
  logic [RB-1:0]         last_resp = '0;
  logic [RB-1:0]         last_tie  = '0;
  logic [RB-1:0][CW-1:0] tgt_a, tgt_b;

  always @(posedge clk) n_edge <= n_edge + 1;

  // Counter model: only reports the target count after exactly WIN enabled cycles.
  always @(posedge clk or posedge reset) begin
    if (reset)            en_cyc <= 0;
    else if (bus.cnt_clr) en_cyc <= 0;
    else if (bus.cnt_en)  en_cyc <= en_cyc + 1;
  end
  assign bus.cnt_a = (en_cyc == WIN) ? tgt_a[bus.pair_sel] : 12'hFFF;
  assign bus.cnt_b = (en_cyc == WIN) ? tgt_b[bus.pair_sel] : 12'hFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        en_run = 0;
      end else begin
        if (bus.cnt_en === 1'b1) begin
          en_run++;
        end else if (en_run != 0) begin
          if (en_chk) chk("cnt_en_window", en_run, WIN);
          en_run = 0;
        end
        if (bus.done === 1'b1) begin
          n_done++;
          if (sb.size() == 0) begin
            chk("unexpected_done", {31'd0, bus.done}, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp", {28'd0, bus.resp}, {28'd0, e.resp});
            chk("tie", {28'd0, bus.tie}, {28'd0, e.tie});
            chk("latency", n_edge - e.t0 + 1, LAT);
            chk("pair_sel_wrap", {30'd0, bus.pair_sel}, 32'd0);
            chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
            last_resp = e.resp;
            last_tie  = e.tie;
          end
        end
      end
    end
  end

  // Caller is #1 after a posedge; start is sampled on the next edge.
  task automatic do_start(input bit push, input logic [RB-1:0] er, input logic [RB-1:0] et);
    exp_t e;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (push) begin
      e.resp = er;
      e.tie  = et;
      e.t0   = n_edge;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit          seen;
    int unsigned nd;

    vecs[0].a = {12'd12, 12'd7, 12'd3, 12'd10};
    vecs[0].b = {12'd11, 12'd7, 12'd9, 12'd5};
    vecs[0].resp = 4'b1001; vecs[0].tie = 4'b0100;
    vecs[1].a = {12'd4094, 12'd1, 12'd0, 12'd4095};
    vecs[1].b = {12'd4095, 12'd0, 12'd0, 12'd4094};
    vecs[1].resp = 4'b0101; vecs[1].tie = 4'b0010;
    vecs[2].a = {12'd100, 12'd100, 12'd100, 12'd100};
    vecs[2].b = {12'd100, 12'd100, 12'd100, 12'd100};
    vecs[2].resp = 4'b0000; vecs[2].tie = 4'b1111;
    vecs[3].a = {12'd4095, 12'd5, 12'd2048, 12'd0};
    vecs[3].b = {12'd0, 12'd6, 12'd2047, 12'd4095};
    vecs[3].resp = 4'b1010; vecs[3].tie = 4'b0000;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    tgt_a = '0;
    tgt_b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cnt_clr",  {31'd0, bus.cnt_clr}, 32'd1);
    chk("rst_cnt_en",   {31'd0, bus.cnt_en}, 32'd0);
    chk("rst_pair_sel", {30'd0, bus.pair_sel}, 32'd0);
    chk("rst_busy",     {31'd0, bus.busy}, 32'd0);
    chk("rst_done",     {31'd0, bus.done}, 32'd0);
    chk("rst_resp",     {28'd0, bus.resp}, 32'd0);
    chk("rst_tie",      {28'd0, bus.tie}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table runs, each started in the cycle right after the previous done.
    for (int i = 0; i < NV; i++) begin
      tgt_a = vecs[i].a;
      tgt_b = vecs[i].b;
      do_start(1'b1, vecs[i].resp, vecs[i].tie);
      chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
      wait_done(seen);
      chk("done_seen", {31'd0, seen}, 32'd1);
      @(posedge clk);
      #1;
      chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
      chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    end

    // start while busy is ignored: one done only.
    tgt_a = vecs[0].a;
    tgt_b = vecs[0].b;
    nd = n_done;
    do_start(1'b1, vecs[0].resp, vecs[0].tie);
    repeat (30) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(seen);
    chk("busy_start_done_seen", {31'd0, seen}, 32'd1);
    repeat (120) @(posedge clk);
    #1;
    chk("busy_start_single_done", n_done - nd, 32'd1);

    // abort during COUNT of pair 2.
    tgt_a = vecs[1].a;
    tgt_b = vecs[1].b;
    en_chk = 1'b0;
    nd = n_done;
    do_start(1'b0, '0, '0);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (bus.pair_sel == 2'd2 && bus.cnt_en === 1'b1) seen = 1'b1;
    end
    chk("abort_reached_count2", {31'd0, seen}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_cnt_en",  {31'd0, bus.cnt_en}, 32'd0);
    chk("abort_cnt_clr", {31'd0, bus.cnt_clr}, 32'd1);
    chk("abort_busy",    {31'd0, bus.busy}, 32'd0);
    chk("abort_resp",    {28'd0, bus.resp}, {28'd0, last_resp});
    chk("abort_tie",     {28'd0, bus.tie}, {28'd0, last_tie});
    repeat (100) @(posedge clk);
    #1;
    chk("abort_no_done", n_done - nd, 32'd0);

    // start and abort together in IDLE: abort wins.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy",    {31'd0, bus.busy}, 32'd0);
    chk("start_abort_cnt_clr", {31'd0, bus.cnt_clr}, 32'd1);

    // async reset mid-run.
    tgt_a = vecs[0].a;
    tgt_b = vecs[0].b;
    nd = n_done;
    do_start(1'b0, '0, '0);
    repeat (40) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_cnt_clr", {31'd0, bus.cnt_clr}, 32'd1);
    chk("midrst_cnt_en",  {31'd0, bus.cnt_en}, 32'd0);
    chk("midrst_busy",    {31'd0, bus.busy}, 32'd0);
    chk("midrst_done",    {31'd0, bus.done}, 32'd0);
    chk("midrst_resp",    {28'd0, bus.resp}, 32'd0);
    chk("midrst_tie",     {28'd0, bus.tie}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    chk("midrst_no_done", n_done - nd, 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
